// File: rtl/clkgate_seq_ctrl.sv
// Clock-branch enable sequencer: wakes a shared gated branch on demand and gates it off after idling.
// Optional cycle-count statistics output ON_CNT is built when CLKGATE_SEQ_STATS_EN is defined.
module clkgate_seq_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] ACK,
  output logic            EN,
  output logic            BUSY
`ifdef CLKGATE_SEQ_STATS_EN
  ,
  output logic [15:0]     ON_CNT
`endif
);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    WAKE = 2'b01,
    ON   = 2'b10,
    HOLD = 2'b11
  } stateT;

  stateT           state, nextState;
  logic [7:0]      cnt, nextCnt;
  logic [NREQ-1:0] ackReg, nextAck;
  logic            enReg, nextEn;

  // State, shared counter, grant and enable are all registered so no REQ path reaches an output.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state  <= OFF;
      cnt    <= 8'd0;
      ackReg <= '0;
      enReg  <= 1'b0;
    end else begin
      state  <= nextState;
      cnt    <= nextCnt;
      ackReg <= nextAck;
      enReg  <= nextEn;
    end
  end

  // Next-state decode; a wake always runs to completion, and HOLD returns to ON without re-waking.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextAck   = '0;
    nextEn    = enReg;
    case (state)
      OFF: begin
        nextEn = 1'b0;
        if (|REQ) begin
          nextState = WAKE;
          nextEn    = 1'b1;
          nextCnt   = 8'(WAKE_CYC - 1);
        end
      end
      WAKE: begin
        nextEn = 1'b1;
        if (cnt != 8'd0) begin
          nextCnt = cnt - 8'd1;
        end else begin
          nextState = ON;
          nextAck   = REQ;
        end
      end
      ON: begin
        nextEn  = 1'b1;
        nextAck = REQ;
        if (REQ == '0) begin
          if (IDLE_CYC == 0) begin
            nextState = OFF;
            nextEn    = 1'b0;
          end else begin
            nextState = HOLD;
            nextCnt   = 8'(IDLE_CYC - 1);
          end
        end
      end
      HOLD: begin
        nextEn = 1'b1;
        if (|REQ) begin
          nextState = ON;
          nextAck   = REQ;
        end else if (cnt == 8'd0) begin
          nextState = OFF;
          nextEn    = 1'b0;
        end else begin
          nextCnt = cnt - 8'd1;
        end
      end
      default: begin
        nextState = OFF;
        nextEn    = 1'b0;
      end
    endcase
  end

  assign ACK  = ackReg;
  assign EN   = enReg;
  assign BUSY = (state != OFF);

`ifdef CLKGATE_SEQ_STATS_EN
  logic [15:0] onCnt;

  // Counts edges at which the branch was enabled, sticking at full scale.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      onCnt <= 16'd0;
    end else if (enReg && (onCnt != 16'hFFFF)) begin
      onCnt <= onCnt + 16'd1;
    end
  end

  assign ON_CNT = onCnt;
`endif

endmodule
